// File: rtl/miriscv_rvfi_trace_streamer.sv
// Buffers RVFI retirement records in a small FIFO and streams each one out as a
// 4..7 beat packet of 32-bit words on a valid/ready trace port.
//
// state   | meaning
// IDLE    | FIFO empty, no beat presented
// HDR     | header beat of head record
// PC      | pc_rdata beat
// INSN    | instruction word beat
// NPC     | pc_wdata beat
// RD      | rd write data beat (only when rd != x0)
// MADDR   | memory address beat (only for memory ops)
// MDATA   | store data, else load data (only for memory ops)
module miriscv_rvfi_trace_streamer #(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        enable_i,
  input  logic        rvfi_valid_i,
  input  logic [63:0] rvfi_order_i,
  input  logic [31:0] rvfi_insn_i,
  input  logic        rvfi_trap_i,
  input  logic        rvfi_intr_i,
  input  logic [31:0] rvfi_pc_rdata_i,
  input  logic [31:0] rvfi_pc_wdata_i,
  input  logic [4:0]  rvfi_rd_addr_i,
  input  logic [31:0] rvfi_rd_wdata_i,
  input  logic [31:0] rvfi_mem_addr_i,
  input  logic [3:0]  rvfi_mem_rmask_i,
  input  logic [3:0]  rvfi_mem_wmask_i,
  input  logic [31:0] rvfi_mem_rdata_i,
  input  logic [31:0] rvfi_mem_wdata_i,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic        core_stall_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_STALL = (AW+1)'(DEPTH - STALL_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PC, S_INSN, S_NPC, S_RD, S_MADDR, S_MDATA
  } state_e;

  // Header is built at push time; has_rd / has_mem live in hdr[25] / hdr[24].
  typedef struct packed {
    logic [31:0] hdr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] npc;
    logic [31:0] rd_wdata;
    logic [31:0] maddr;
    logic [31:0] mdata;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        mem_q [DEPTH];
  entry_t        entry_d;
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic          push_req, push_acc, drop, pop, fire, full;
  logic          has_rd_in, has_mem_in, head_has_rd, head_has_mem;
  logic          unused_order;

  assign unused_order = ^rvfi_order_i[63:11];

  assign head         = mem_q[rd_ptr_q];
  assign head_has_rd  = head.hdr[25];
  assign head_has_mem = head.hdr[24];

  always_comb begin
    has_rd_in      = |rvfi_rd_addr_i;
    has_mem_in     = |(rvfi_mem_rmask_i | rvfi_mem_wmask_i);
    entry_d.hdr    = {4'hA, rvfi_trap_i, rvfi_intr_i, has_rd_in, has_mem_in,
                      rvfi_rd_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i,
                      rvfi_order_i[10:0]};
    entry_d.pc       = rvfi_pc_rdata_i;
    entry_d.insn     = rvfi_insn_i;
    entry_d.npc      = rvfi_pc_wdata_i;
    entry_d.rd_wdata = rvfi_rd_wdata_i;
    entry_d.maddr    = rvfi_mem_addr_i;
    entry_d.mdata    = (|rvfi_mem_wmask_i) ? rvfi_mem_wdata_i : rvfi_mem_rdata_i;
  end

  // A full FIFO still accepts when the head packet finishes in the same cycle.
  always_comb begin
    push_req   = rvfi_valid_i & enable_i;
    full       = (occ_q == OCC_FULL);
    fire       = trace_valid_o & trace_ready_i;
    pop        = fire & trace_last_o;
    push_acc   = push_req & (~full | pop);
    drop       = push_req & ~push_acc;
    wr_ptr_d   = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d      = occ_q;
    case ({push_acc, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= entry_d;
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (occ_d != '0) state_d = S_HDR;
    end else if (fire) begin
      if (trace_last_o) begin
        state_d = (occ_d != '0) ? S_HDR : S_IDLE;
      end else begin
        case (state_q)
          S_HDR:   state_d = S_PC;
          S_PC:    state_d = S_INSN;
          S_INSN:  state_d = S_NPC;
          S_NPC:   state_d = head_has_rd ? S_RD : S_MADDR;
          S_RD:    state_d = S_MADDR;
          S_MADDR: state_d = S_MDATA;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    trace_valid_o = (state_q != S_IDLE);
    trace_data_o  = '0;
    trace_last_o  = 1'b0;
    case (state_q)
      S_HDR:   trace_data_o = head.hdr;
      S_PC:    trace_data_o = head.pc;
      S_INSN:  trace_data_o = head.insn;
      S_NPC: begin
        trace_data_o = head.npc;
        trace_last_o = ~head_has_rd & ~head_has_mem;
      end
      S_RD: begin
        trace_data_o = head.rd_wdata;
        trace_last_o = ~head_has_mem;
      end
      S_MADDR: trace_data_o = head.maddr;
      S_MDATA: begin
        trace_data_o = head.mdata;
        trace_last_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_stall_o = (occ_q >= OCC_STALL);
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
